rgb_fade_sequencer: RTL

Upstream brightness generator for the RGB LED path. It produces one WIDTH-bit PWM level per colour channel and feeds three PWM comparator instances, whose outputs go to the RGB LED driver pins.
- Fades one channel at a time: linear ramp up, ramp down, optional dark gap, then advance red -> green -> blue -> red.
- Step rate is set by an internal prescaler.

---
 rtl/rgb_fade_sequencer.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/rgb_fade_sequencer.sv
// rgb_fade_sequencer: brightness source for the three RGB PWM comparators.
// Ramps one colour channel at a time from dark to full scale and back,
// optionally waits dark for GAP_TICKS steps, then moves on red -> green ->
// blue -> red. An internal prescaler sets how often the level steps.
// Optional feature macro: RGB_FADE_GAMMA_EN (quadratic output curve).
module rgb_fade_sequencer #(
    parameter int PRESCALER_BITS = 16,
    parameter int WIDTH          = 8,
    parameter int GAP_TICKS      = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] level_red,
    output logic [WIDTH-1:0] level_green,
    output logic [WIDTH-1:0] level_blue,
    output logic [1:0]       channel,
    output logic             cycle_done
);

    typedef enum logic [1:0] {
        ST_RISE = 2'd0,
        ST_FALL = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] LEVEL_MAX  = '1;
    localparam logic [WIDTH-1:0] LEVEL_ZERO = '0;
    localparam logic [WIDTH-1:0] LEVEL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [7:0]       GAP_LAST   = 8'(GAP_TICKS);

    logic             tick;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [1:0]       channel_q, channel_d;
    logic [7:0]       gap_q, gap_d;
    logic [WIDTH-1:0] level_inc, level_dec;
    logic [7:0]       gap_inc;
    logic [1:0]       channel_next;
    logic [WIDTH-1:0] shaped;

    // Step strobe: either every enabled clock, or once per prescaler wrap.
    generate
        if (PRESCALER_BITS == 0) begin : g_no_prescaler
            assign tick = en;
        end else begin : g_prescaler
            localparam logic [PRESCALER_BITS-1:0] PRESC_ONE = 1;
            logic [PRESCALER_BITS-1:0] presc_count;

            // Free-running divider; freezes with its partial count while en is low.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    presc_count <= '0;
                end else if (en) begin
                    presc_count <= presc_count + PRESC_ONE;
                end
            end

            assign tick = en && (&presc_count);
        end
    endgenerate

    assign level_inc    = level_q + LEVEL_ONE;
    assign level_dec    = level_q - LEVEL_ONE;
    assign gap_inc      = gap_q + 8'd1;
    assign channel_next = (channel_q == 2'd2) ? 2'd0 : channel_q + 2'd1;

    // Sequencer state: only moves on a step tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_RISE;
            level_q   <= '0;
            channel_q <= 2'd0;
            gap_q     <= 8'd0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            channel_q <= channel_d;
            gap_q     <= gap_d;
        end
    end

    // Next-state logic: turn around at full scale, leave the channel at zero
    // (directly, or after the dark gap when one is configured).
    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        channel_d = channel_q;
        gap_d     = gap_q;
        if (tick) begin
            case (state_q)
                ST_RISE: begin
                    level_d = level_inc;
                    if (level_inc == LEVEL_MAX) begin
                        state_d = ST_FALL;
                    end
                end
                ST_FALL: begin
                    level_d = level_dec;
                    if (level_dec == LEVEL_ZERO) begin
                        if (GAP_TICKS == 0) begin
                            state_d   = ST_RISE;
                            channel_d = channel_next;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    level_d = '0;
                    if (gap_inc == GAP_LAST) begin
                        gap_d     = 8'd0;
                        channel_d = channel_next;
                        state_d   = ST_RISE;
                    end else begin
                        gap_d = gap_inc;
                    end
                end
                default: begin
                    state_d = ST_RISE;
                    level_d = '0;
                    gap_d   = 8'd0;
                end
            endcase
        end
    end

`ifdef RGB_FADE_GAMMA_EN
    logic [2*WIDTH-1:0] square;
    logic [WIDTH:0]     bumped;

    // Quadratic curve: (L*L >> WIDTH) + 1 for nonzero L, clamped to full scale.
    always_comb begin
        square = {{WIDTH{1'b0}}, level_q} * {{WIDTH{1'b0}}, level_q};
        bumped = {1'b0, square[2*WIDTH-1:WIDTH]} + {{WIDTH{1'b0}}, 1'b1};
        shaped = '0;
        if (level_q != LEVEL_ZERO) begin
            shaped = bumped[WIDTH] ? LEVEL_MAX : bumped[WIDTH-1:0];
        end
    end
`else
    // Linear curve: the output level is the ramp level itself.
    always_comb begin
        shaped = level_q;
    end
`endif

    // Output register: steer the level to the active channel one clock later;
    // cycle_done marks the first registered view of red after blue, and is
    // dropped while frozen so it can never stretch beyond one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_red   <= '0;
            level_green <= '0;
            level_blue  <= '0;
            channel     <= 2'd0;
            cycle_done  <= 1'b0;
        end else if (en) begin
            level_red   <= (channel_q == 2'd0) ? shaped : LEVEL_ZERO;
            level_green <= (channel_q == 2'd1) ? shaped : LEVEL_ZERO;
            level_blue  <= (channel_q == 2'd2) ? shaped : LEVEL_ZERO;
            channel     <= channel_q;
            cycle_done  <= (channel_q == 2'd0) && (channel == 2'd2);
        end else begin
            cycle_done  <= 1'b0;
        end
    end

endmodule
